// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: assembles command frames from a synchronized byte stream and
// issues registered register-file / ALU request pulses with a stall timeout.
module cmd_frame_rx #(
    parameter int data_width     = 8,
    parameter int addr_width     = 4,
    parameter int func_width     = 4,
    parameter int timeout_cycles = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  out_wr_en,
    output logic                  out_rd_en,
    output logic                  out_alu_en,
    output logic                  out_alu_op_load,
    output logic [addr_width-1:0] out_addr,
    output logic [data_width-1:0] out_wr_data,
    output logic [data_width-1:0] out_op_a,
    output logic [data_width-1:0] out_op_b,
    output logic [func_width-1:0] out_func,
    output logic                  out_busy,
    output logic                  out_err
);
    localparam int cw = $clog2(timeout_cycles);
    localparam logic [data_width-1:0] cmd_wr  = data_width'(8'hAA);
    localparam logic [data_width-1:0] cmd_rd  = data_width'(8'hBB);
    localparam logic [data_width-1:0] cmd_alu = data_width'(8'hCC);
    localparam logic [data_width-1:0] cmd_fn  = data_width'(8'hDD);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN, FN_ONLY} state_t;
    state_t state, state_nxt;
    logic [cw-1:0] cnt, cnt_nxt;
    logic wr_nxt, rd_nxt, alu_nxt, load_nxt, err_nxt, timeout;
    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        alu_nxt   = 1'b0;
        load_nxt  = 1'b0;
        err_nxt   = 1'b0;
        timeout   = state != IDLE && !in_valid && cnt == cw'(timeout_cycles - 1);
        if (timeout) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    state_nxt = in_data == cmd_wr  ? WR_ADDR :
                                in_data == cmd_rd  ? RD_ADDR :
                                in_data == cmd_alu ? ALU_A   :
                                in_data == cmd_fn  ? FN_ONLY : IDLE;
                    err_nxt   = state_nxt == IDLE;
                end
                WR_ADDR: state_nxt = WR_DATA;
                WR_DATA: begin
                    state_nxt = IDLE;
                    wr_nxt    = 1'b1;
                end
                RD_ADDR: begin
                    state_nxt = IDLE;
                    rd_nxt    = 1'b1;
                end
                ALU_A: state_nxt = ALU_B;
                ALU_B: state_nxt = ALU_FN;
                ALU_FN: begin
                    state_nxt = IDLE;
                    alu_nxt   = 1'b1;
                    load_nxt  = 1'b1;
                end
                FN_ONLY: begin
                    state_nxt = IDLE;
                    alu_nxt   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
        cnt_nxt = (state_nxt == IDLE || in_valid) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            out_wr_en       <= 1'b0;
            out_rd_en       <= 1'b0;
            out_alu_en      <= 1'b0;
            out_alu_op_load <= 1'b0;
            out_err         <= 1'b0;
            out_busy        <= 1'b0;
            out_addr        <= '0;
            out_wr_data     <= '0;
            out_op_a        <= '0;
            out_op_b        <= '0;
            out_func        <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            out_wr_en       <= wr_nxt;
            out_rd_en       <= rd_nxt;
            out_alu_en      <= alu_nxt;
            out_alu_op_load <= load_nxt;
            out_err         <= err_nxt;
            out_busy        <= state_nxt != IDLE;
            // a valid byte never coincides with a timeout, so in_valid alone gates field loads
            if (in_valid && (state == WR_ADDR || state == RD_ADDR)) out_addr <= in_data[addr_width-1:0];
            if (in_valid && state == WR_DATA) out_wr_data <= in_data;
            if (in_valid && state == ALU_A) out_op_a <= in_data;
            if (in_valid && state == ALU_B) out_op_b <= in_data;
            if (in_valid && (state == ALU_FN || state == FN_ONLY)) out_func <= in_data[func_width-1:0];
        end
    end
endmodule

// File: tb/tb_cmd_frame_rx.sv
// tb_cmd_frame_rx: directed frames with a scoreboard of expected request/error pulses.
module tb_cmd_frame_rx;
    localparam int T = 16;
    localparam logic [4:0] WR = 5'b10000, RD = 5'b01000, ALUL = 5'b00110, ALU = 5'b00100, ERR = 5'b00001;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic out_wr_en, out_rd_en, out_alu_en, out_alu_op_load, out_busy, out_err;
    logic [3:0] out_addr, out_func;
    logic [7:0] out_wr_data, out_op_a, out_op_b;
    logic [36:0] obs;
    int cyc = 0, checks = 0, fails = 0;
    typedef struct {
        logic [36:0] v;
        int          c;
        string       name;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    cmd_frame_rx #(.data_width(8), .addr_width(4), .func_width(4), .timeout_cycles(T)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_wr_en(out_wr_en), .out_rd_en(out_rd_en), .out_alu_en(out_alu_en),
        .out_alu_op_load(out_alu_op_load), .out_addr(out_addr), .out_wr_data(out_wr_data),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_func(out_func),
        .out_busy(out_busy), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign obs = {out_wr_en, out_rd_en, out_alu_en, out_alu_op_load, out_err,
                  out_addr, out_wr_data, out_op_a, out_op_b, out_func};

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [4:0] fl, input logic [3:0] ad,
                        input logic [7:0] wd, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, input int off);
        exp_t x;
        x.v = {fl, ad, wd, a, b, f};
        x.c = cyc + off;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: every pulse must match the oldest expectation, on the expected cycle
    always @(negedge clk) begin
        if (obs[36:32] != 5'b0) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: got %h expected none", obs);
            end else begin
                e = sb.pop_front();
                chk(e.name, obs, e.v);
                chk({e.name, "_cycle"}, 37'(cyc), 37'(e.c));
            end
        end
    end

    initial begin
        @(posedge clk);
        #1 chk("reset_outputs", obs, '0);
        chk("reset_busy", 37'(out_busy), '0);
        idle(1);
        rst = 1'b0;
        send(8'hAA);
        chk("busy_rise", 37'(out_busy), 37'(1));
        send(8'h05);
        send(8'h5A);
        push("write", WR, 4'h5, 8'h5A, 8'h00, 8'h00, 4'h0, 0);
        chk("busy_fall", 37'(out_busy), '0);
        idle(2);
        send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
        push("alu_ops", ALUL, 4'h5, 8'h5A, 8'h12, 8'h34, 4'h2, 0);
        send(8'hDD); send(8'h07);
        push("alu_fn_only", ALU, 4'h5, 8'h5A, 8'h12, 8'h34, 4'h7, 0);
        idle(2);
        send(8'hAA); idle(10); send(8'h0F); idle(3); send(8'hFF);
        push("gapped_write", WR, 4'hF, 8'hFF, 8'h12, 8'h34, 4'h7, 0);
        idle(2);
        send(8'hAA); send(8'h01);
        push("timeout", ERR, 4'h1, 8'hFF, 8'h12, 8'h34, 4'h7, T);
        idle(T - 1);
        chk("busy_before_timeout", 37'(out_busy), 37'(1));
        idle(1);
        chk("busy_after_timeout", 37'(out_busy), '0);
        idle(3);
        send(8'hAA); send(8'h02); idle(T - 1); send(8'h77);
        push("threshold_byte", WR, 4'h2, 8'h77, 8'h12, 8'h34, 4'h7, 0);
        idle(T + 2);
        send(8'h42);
        push("unknown_cmd", ERR, 4'h2, 8'h77, 8'h12, 8'h34, 4'h7, 0);
        chk("unknown_busy", 37'(out_busy), '0);
        send(8'hBB); send(8'h09);
        push("read_after_unknown", RD, 4'h9, 8'h77, 8'h12, 8'h34, 4'h7, 0);
        idle(2);
        send(8'hAA); send(8'hAA); send(8'hBB);
        push("cmd_as_payload", WR, 4'hA, 8'hBB, 8'h12, 8'h34, 4'h7, 0);
        idle(2);
        send(8'hCC); send(8'h11); send(8'h22);
        #3 rst = 1'b1;
        #1 chk("async_reset_outputs", obs, '0);
        chk("async_reset_busy", 37'(out_busy), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'hBB); send(8'h03);
        push("read_after_reset", RD, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 0);
        idle(T + 4);
        chk("scoreboard_drained", 37'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
